// File: rtl/regfile_access_master_if.sv
// Command, response and register-file pins of regfile_access_master.
// The master modport is the sequencer's view; slave is the front-end/register-file side.
interface regfile_access_master_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_address;
    logic [DW-1:0] cmd_wdata;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;

    logic          rf_write_enable;
    logic [AW-1:0] rf_write_address;
    logic [DW-1:0] rf_write_data;
    logic [AW-1:0] rf_read_address_1;
    logic [DW-1:0] rf_read_data_1;
    logic [AW-1:0] rf_read_address_2;
    logic [DW-1:0] rf_read_data_2;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_wdata,
        input  rsp_ready,
        input  rf_read_data_1, rf_read_data_2,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_error,
        output rf_write_enable, rf_write_address, rf_write_data,
        output rf_read_address_1, rf_read_address_2
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_wdata,
        output rsp_ready,
        output rf_read_data_1, rf_read_data_2,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_error,
        input  rf_write_enable, rf_write_address, rf_write_data,
        input  rf_read_address_1, rf_read_address_2
    );
endinterface

// File: rtl/regfile_access_master.sv
// Command-FIFO sequencer driving a register file; one response per command.
// Optional macro READBACK_CHECK_EN: read back each write on port 2 and flag mismatches.
module regfile_access_master #(
    parameter int NUM_ADDRESS = 16,
    parameter int DATA_LENGTH = 32,
    parameter int CMD_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_access_master_if.master bus
);
    localparam int AW = $clog2(NUM_ADDRESS);
    localparam int DW = DATA_LENGTH;
    localparam int PW = $clog2(CMD_DEPTH);

    if (NUM_ADDRESS < 2) begin : g_bad_num_address
        $error("regfile_access_master: NUM_ADDRESS must be greater than 1");
    end
    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_cmd_depth
        $error("regfile_access_master: CMD_DEPTH must be a power of two >= 2");
    end

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    cmd_t          fifo_mem_q [CMD_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          fifo_full, fifo_empty;
    logic          push, pop;
    cmd_t          cmd_in;

    state_t        state_q, state_d;
    cmd_t          cmd_q, cmd_d;
    logic          rsp_write_q, rsp_write_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_error_q, rsp_error_d;
    logic          addr_ok;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < NUM_ADDRESS;
    endfunction

    assign fifo_full     = (count_q == (PW+1)'(CMD_DEPTH));
    assign fifo_empty    = (count_q == '0);
    assign bus.cmd_ready = !fifo_full;
    assign push          = bus.cmd_valid && !fifo_full;
    assign addr_ok       = in_range(cmd_q.addr);

    assign cmd_in.write = bus.cmd_write;
    assign cmd_in.addr  = bus.cmd_address;
    assign cmd_in.wdata = bus.cmd_wdata;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    // Payload storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        cmd_d       = cmd_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;

        bus.rsp_valid         = 1'b0;
        bus.rf_write_enable   = 1'b0;
        bus.rf_write_address  = '0;
        bus.rf_write_data     = '0;
        bus.rf_read_address_1 = '0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cmd_d   = fifo_mem_q[rd_ptr_q];
                    state_d = EXEC;
                end
            end

            // The register file commits the write on the EXEC->RESP edge, so a
            // following read of the same address already sees the new value.
            EXEC: begin
                bus.rf_write_enable   = cmd_q.write && addr_ok;
                bus.rf_write_address  = cmd_q.addr;
                bus.rf_write_data     = cmd_q.wdata;
                bus.rf_read_address_1 = cmd_q.addr;

                rsp_write_d = cmd_q.write;
                rsp_rdata_d = (!cmd_q.write && addr_ok) ? bus.rf_read_data_1 : '0;
                rsp_error_d = !addr_ok;
                state_d     = RESP;
            end

            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        cmd_d   = fifo_mem_q[rd_ptr_q];
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_q       <= '0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_q       <= cmd_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;

`ifdef READBACK_CHECK_EN
    logic readback_active;

    // Port 2 re-reads the just-written entry; the compare is stable for all of RESP.
    assign readback_active       = (state_q == RESP) && rsp_write_q;
    assign bus.rf_read_address_2 = readback_active ? cmd_q.addr : '0;
    assign bus.rsp_error         = rsp_error_q ||
                                   (readback_active && (bus.rf_read_data_2 != cmd_q.wdata));
`else
    logic unused_read_data_2;

    assign unused_read_data_2    = ^bus.rf_read_data_2;
    assign bus.rf_read_address_2 = '0;
    assign bus.rsp_error         = rsp_error_q;
`endif

endmodule

// File: tb/tb_regfile_access_master.sv
// Directed bench for regfile_access_master with a behavioural 12-entry register file.
module tb_regfile_access_master;
    localparam int NA    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic reset;
    logic model_init;
    logic rd2_corrupt;

    always #5 clk = ~clk;

    regfile_access_master_if #(.AW(AW), .DW(DW)) bus ();

    regfile_access_master #(
        .NUM_ADDRESS (NA),
        .DATA_LENGTH (DW),
        .CMD_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] rf_mem [NA];

    function automatic logic [DW-1:0] rf_rd(input logic [AW-1:0] a);
        if (32'(a) < NA) return rf_mem[a];
        return 32'hBAD0_0000 | 32'(a);
    endfunction

    always @(posedge clk) begin
        if (model_init) begin
            for (int i = 0; i < NA; i++) rf_mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (bus.rf_write_enable && (32'(bus.rf_write_address) < NA)) begin
            rf_mem[bus.rf_write_address] <= bus.rf_write_data;
        end
    end

    assign bus.rf_read_data_1 = rf_rd(bus.rf_read_address_1);
    assign bus.rf_read_data_2 = rd2_corrupt ? '0 : rf_rd(bus.rf_read_address_2);

    typedef struct {
        logic          write;
        logic [DW-1:0] rdata;
        logic          error;
        int            cyc;
    } rsp_t;

    rsp_t rsp_q [$];
    int   cyc    = 0;
    int   we_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset && bus.rsp_valid && bus.rsp_ready)
            rsp_q.push_back('{write: bus.rsp_write, rdata: bus.rsp_rdata,
                              error: bus.rsp_error, cyc: cyc});
        if (bus.rf_write_enable) we_cnt <= we_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_write   = w;
        bus.cmd_address = a;
        bus.cmd_wdata   = d;
        while (!bus.cmd_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.cmd_ready) chk("push_timeout", 0, 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int n, input int budget);
        int t = 0;
        while (rsp_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        if (rsp_q.size() < n) chk(tag, rsp_q.size(), n);
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        while (!bus.rsp_valid && t < 10) begin
            tick();
            t++;
        end
        chk(tag, bus.rsp_valid, 1);
    endtask

    task automatic check_reset_outputs(input string p);
        chk({p, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({p, "_rsp_write"}, bus.rsp_write, 0);
        chk({p, "_rsp_rdata"}, bus.rsp_rdata, 0);
        chk({p, "_rsp_error"}, bus.rsp_error, 0);
        chk({p, "_we"}, bus.rf_write_enable, 0);
        chk({p, "_waddr"}, bus.rf_write_address, 0);
        chk({p, "_wdata"}, bus.rf_write_data, 0);
        chk({p, "_raddr1"}, bus.rf_read_address_1, 0);
        chk({p, "_raddr2"}, bus.rf_read_address_2, 0);
        chk({p, "_cmd_ready"}, bus.cmd_ready, 1);
    endtask

    logic          bp_w [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [AW-1:0] bp_a [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0};
    logic [DW-1:0] bp_d [6] = '{32'hA0, 32'h0, 32'hB0, 32'h0, 32'h0, 32'hFF};
    logic [DW-1:0] bp_x [5] = '{32'h0, 32'hA0, 32'h0, 32'hB0, 32'hDEADBEEF};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int acc;
        logic rdy;

        reset           = 1'b0;
        model_init      = 1'b1;
        rd2_corrupt     = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = 1'b0;
        bus.cmd_address = '0;
        bus.cmd_wdata   = '0;
        bus.rsp_ready   = 1'b0;
        tick(); tick(); tick();
        check_reset_outputs("rst");
        reset      = 1'b1;
        model_init = 1'b0;
        tick();

        // Single write: pop one edge after push, commit and rsp_valid one edge later.
        bus.rsp_ready = 1'b1;
        base = we_cnt;
        push_cmd(1'b1, 4'd3, 32'hDEADBEEF);
        chk("t1_we_before_pop", bus.rf_write_enable, 0);
        chk("t1_valid_e0", bus.rsp_valid, 0);
        tick();
        chk("t1_we_exec", bus.rf_write_enable, 1);
        chk("t1_waddr", bus.rf_write_address, 3);
        chk("t1_wdata", bus.rf_write_data, 32'hDEADBEEF);
        chk("t1_valid_e1", bus.rsp_valid, 0);
        tick();
        chk("t1_we_resp", bus.rf_write_enable, 0);
        chk("t1_valid_e2", bus.rsp_valid, 1);
        chk("t1_rsp_write", bus.rsp_write, 1);
        chk("t1_rsp_error", bus.rsp_error, 0);
        chk("t1_mem3", rf_mem[3], 32'hDEADBEEF);
        tick();
        chk("t1_valid_after", bus.rsp_valid, 0);
        chk("t1_we_pulses", we_cnt - base, 1);

        // Write then read of the same address, back to back.
        rsp_q.delete();
        push_cmd(1'b1, 4'd5, 32'h12345678);
        push_cmd(1'b0, 4'd5, 32'h0);
        wait_rsp("t2_rsp_timeout", 2, 20);
        if (rsp_q.size() >= 2) begin
            chk("t2_r0_write", rsp_q[0].write, 1);
            chk("t2_r0_error", rsp_q[0].error, 0);
            chk("t2_r1_write", rsp_q[1].write, 0);
            chk("t2_r1_rdata", rsp_q[1].rdata, 32'h12345678);
            chk("t2_r1_error", rsp_q[1].error, 0);
            chk("t2_spacing", rsp_q[1].cyc - rsp_q[0].cyc, 2);
        end

        // Backpressure: one command in RESP plus DEPTH queued, then full.
        tick();
        rsp_q.delete();
        bus.rsp_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            if (acc < 6) begin
                bus.cmd_valid   = 1'b1;
                bus.cmd_write   = bp_w[acc];
                bus.cmd_address = bp_a[acc];
                bus.cmd_wdata   = bp_d[acc];
            end else begin
                bus.cmd_valid = 1'b0;
            end
            rdy = bus.cmd_ready;
            tick();
            if (rdy && bus.cmd_valid) acc++;
        end
        bus.cmd_valid = 1'b0;
        chk("t3_accepted", acc, 5);
        chk("t3_cmd_ready_full", bus.cmd_ready, 0);
        chk("t3_stalled_valid", bus.rsp_valid, 1);
        chk("t3_no_rsp_yet", rsp_q.size(), 0);
        bus.rsp_ready = 1'b1;
        wait_rsp("t3_rsp_timeout", 5, 40);
        for (int k = 0; k < 6; k++) tick();
        chk("t3_rsp_count", rsp_q.size(), 5);
        if (rsp_q.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("t3_r%0d_write", k), rsp_q[k].write, bp_w[k]);
                chk($sformatf("t3_r%0d_rdata", k), rsp_q[k].rdata, bp_x[k]);
            end
        end
        chk("t3_mem0", rf_mem[0], 32'hB0);
        chk("t3_cmd_ready_drained", bus.cmd_ready, 1);

        // Out-of-range address 13 with 12 entries.
        rsp_q.delete();
        base = we_cnt;
        push_cmd(1'b1, 4'd13, 32'h77);
        push_cmd(1'b0, 4'd13, 32'h0);
        wait_rsp("t4_rsp_timeout", 2, 20);
        tick(); tick();
        chk("t4_no_we", we_cnt - base, 0);
        if (rsp_q.size() >= 2) begin
            chk("t4_r0_write", rsp_q[0].write, 1);
            chk("t4_r0_error", rsp_q[0].error, 1);
            chk("t4_r1_write", rsp_q[1].write, 0);
            chk("t4_r1_rdata", rsp_q[1].rdata, 0);
            chk("t4_r1_error", rsp_q[1].error, 1);
        end

        // Reset during EXEC of write 7 with write 8 still queued.
        rsp_q.delete();
        push_cmd(1'b1, 4'd7, 32'h77777777);
        push_cmd(1'b1, 4'd8, 32'h88888888);
        chk("t5_in_exec_we", bus.rf_write_enable, 1);
        chk("t5_in_exec_addr", bus.rf_write_address, 7);
        reset = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        base = we_cnt;
        tick();
        chk("t5_mem7", rf_mem[7], 32'h1000_0007);
        chk("t5_mem8", rf_mem[8], 32'h1000_0008);
        check_reset_outputs("t5_held");
        reset = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        chk("t5_no_rsp", rsp_q.size(), 0);
        chk("t5_no_we", we_cnt - base, 0);
        chk("t5_mem7_after", rf_mem[7], 32'h1000_0007);
        chk("t5_cmd_ready", bus.cmd_ready, 1);

        // Readback of write data on port 2.
        bus.rsp_ready = 1'b0;
        rd2_corrupt   = 1'b1;
        push_cmd(1'b1, 4'd2, 32'hA5A5A5A5);
        wait_valid("t6_bad_valid");
`ifdef READBACK_CHECK_EN
        chk("t6_bad_error", bus.rsp_error, 1);
        chk("t6_bad_raddr2", bus.rf_read_address_2, 2);
`else
        chk("t6_bad_error", bus.rsp_error, 0);
        chk("t6_bad_raddr2", bus.rf_read_address_2, 0);
`endif
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        rd2_corrupt   = 1'b0;
        push_cmd(1'b1, 4'd2, 32'hA5A5A5A5);
        wait_valid("t6_good_valid");
        chk("t6_good_error", bus.rsp_error, 0);
        chk("t6_mem2", rf_mem[2], 32'hA5A5A5A5);
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        chk("t6_idle", bus.rsp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_access_master.md
Name: regfile_access_master

Overview:
Initiator-side sequencer that drives the write port and read ports of the register file block from a valid/ready command stream. It buffers commands in a small FIFO and executes them one at a time against the register file. Each command returns exactly one response on a valid/ready response channel. It sits between a bus/CSR front-end and the register file, and is the only agent driving the register file's address, data and enable pins.

Parameters:
NUM_ADDRESS, 16, number of register file entries; must be >1; address width AW = $clog2(NUM_ADDRESS)
DATA_LENGTH, 32, register width in bits (DW)
CMD_DEPTH, 4, command FIFO depth; must be a power of two, ≥2

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command FIFO not full
cmd_write  input  1  1 = write, 0 = read
cmd_address  input  AW  target register
cmd_wdata  input  DW  write data (ignored for reads)
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_write  output  1  echo of executed command type
rsp_rdata  output  DW  read data (0 for writes)
rsp_error  output  1  response error flag
rf_write_enable  output  1  to register file write_enable
rf_write_address  output  AW  to register file write_address
rf_write_data  output  DW  to register file write_data_in
rf_read_address_1  output  AW  to register file read_address_1
rf_read_data_1  input  DW  from register file read_data_out_1 (combinational read)
rf_read_address_2  output  AW  to register file read_address_2
rf_read_data_2  input  DW  from register file read_data_out_2

Behaviour:
- Reset (reset=0, async): FIFO empty, FSM=IDLE, command register cleared.
- Reset values: rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_error=0, rf_write_enable=0, all rf addresses/data=0, cmd_ready=1.
- Command FIFO:
  - push on cmd_valid&cmd_ready; cmd_ready = !full (no same-cycle pass-through when full).
  - Pointers wrap modulo CMD_DEPTH; count range 0..CMD_DEPTH.
- FSM states IDLE, EXEC, RESP:
  - IDLE: if FIFO non-empty, pop head into command register -> EXEC; else stay.
  - EXEC (exactly 1 cycle):
    - rf_write_address/rf_write_data/rf_read_address_1 = command register.
    - rf_write_enable = cmd_write & (address < NUM_ADDRESS), combinational from state, so the register file commits at the EXEC->RESP edge.
    - For reads, capture rsp_rdata = (address < NUM_ADDRESS) ? rf_read_data_1 : 0 at the same edge.
    - -> RESP.
  - RESP: rsp_valid=1, with rsp_write/rsp_rdata/rsp_error held stable until rsp_ready.
    - On handshake: if FIFO non-empty, pop -> EXEC; else -> IDLE.
- rf_write_enable is asserted only in EXEC; never in IDLE or RESP.
- Latency: command pushed at edge E0 into an empty FIFO in IDLE: pop at E1, write commits at E2, rsp_valid=1 from E2. With rsp_ready held 1, sustained throughput is one command per 2 cycles.
- Ordering:
  - Strict FIFO order.
  - A read following a write to the same address returns the new data, because the write commits before the next EXEC.
- Out-of-range address (≥NUM_ADDRESS, non-power-of-two sizes):
  - Write suppressed; read returns 0.
  - Response still generated with rsp_error=1.
- Backpressure: rsp_ready=0 stalls the FSM in RESP. The FIFO keeps accepting until full.
- Reset mid-operation: in-flight and queued commands are discarded, and no response is produced for them. A write not yet at its commit edge does not occur.

Optional Feature:
READBACK_CHECK_EN:
- Defined:
  - In RESP for a write, rf_read_address_2 = command address.
  - rsp_error additionally = (rf_read_data_2 != command wdata), or'd with the out-of-range error.
  - Compare is combinational and stable while in RESP, since the register file was updated at the EXEC->RESP edge.
- Undefined: rf_read_address_2 tied to 0, rf_read_data_2 ignored, and rsp_error reflects only the out-of-range error.

Test Plan:
- Reset then write addr 3 data 0xDEADBEEF, rsp_ready=1 -> rf_write_enable high exactly 1 cycle with addr 3. rsp_valid rises 2 cycles after the push edge, with rsp_write=1, rsp_error=0.
- Write addr 5=0x12345678, then read addr 5 back-to-back -> read response rsp_rdata=0x12345678. Responses arrive in order, 2 cycles apart.
- Hold rsp_ready=0, push 1+CMD_DEPTH commands -> cmd_ready drops after 5 accepted (1 in RESP + 4 queued). Release rsp_ready -> 5 ordered responses, no loss or duplication.
- NUM_ADDRESS=12, write addr 13 then read addr 13 -> no rf_write_enable pulse. Read rsp_rdata=0; both responses have rsp_error=1.
- Assert reset during EXEC of a write to addr 7 -> register 7 unchanged, all outputs at reset values, FIFO empty, cmd_ready=1.
- READBACK_CHECK_EN defined, model forces rf_read_data_2=0x0 on write 0xA5A5A5A5 to addr 2 -> rsp_error=1. With the matching model, rsp_error=0.
